// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the requester-side and UART-side handshake signals of the
// transmit arbiter. The arbiter uses the master view; the requesters, the
// UART transmitter and status observers together use the slave view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  en;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*8-1:0]  req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  tx_start;
  logic [7:0]            tx_data;
  logic                  tx_active;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;
  logic                  done;
  logic                  err_timeout;

  modport master (
    input  en, req_valid, req_data, tx_active,
    output req_ready, tx_start, tx_data, grant_id, busy, done, err_timeout
  );

  modport slave (
    output en, req_valid, req_data, tx_active,
    input  req_ready, tx_start, tx_data, grant_id, busy, done, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte sources share one UART
// transmitter. A winner's byte is latched, handed to the UART with a one-cycle
// start pulse, and the arbiter then follows tx_active through its busy period.
// If the UART never goes active within START_TO cycles the byte is dropped
// and a timeout pulse is raised. Every output comes straight from a flop.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int START_TO = 16
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_arbiter_if.master   bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(START_TO + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(START_TO);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACT,
    WAIT_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 txStart_q, txStart_d;
  logic [NUM_REQ-1:0]   reqReady_q, reqReady_d;
  logic [7:0]           txData_q, txData_d;
  logic [ID_W-1:0]      grantId_q, grantId_d;
  logic [ID_W-1:0]      lastGrant_q, lastGrant_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 errTimeout_q, errTimeout_d;

  logic                 winFound;
  logic [ID_W-1:0]      winId;
  logic [7:0]           winData;
  logic [NUM_REQ-1:0]   winOneHot;

  // Round-robin pick: first look above the last owner, then wrap to the bottom
  always_comb begin
    winFound  = 1'b0;
    winId     = '0;
    winData   = '0;
    winOneHot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!winFound && bus.req_valid[i] && (i > int'(lastGrant_q))) begin
        winFound = 1'b1;
        winId    = ID_W'(i);
        winData  = bus.req_data[i*8 +: 8];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!winFound && bus.req_valid[i] && (i <= int'(lastGrant_q))) begin
        winFound = 1'b1;
        winId    = ID_W'(i);
        winData  = bus.req_data[i*8 +: 8];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      winOneHot[i] = winFound && (winId == ID_W'(i));
    end
  end

  // Next-state and next-output logic; pulses default low, held data defaults to hold
  always_comb begin
    state_d      = state_q;
    txStart_d    = 1'b0;
    reqReady_d   = '0;
    doneDefault();
    txData_d     = txData_q;
    grantId_d    = grantId_q;
    lastGrant_d  = lastGrant_q;
    timer_d      = timer_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en && !bus.tx_active && winFound) begin
          state_d     = START;
          txStart_d   = 1'b1;
          reqReady_d  = winOneHot;
          txData_d    = winData;
          grantId_d   = winId;
          lastGrant_d = winId;
        end
      end
      START: begin
        state_d = WAIT_ACT;
        timer_d = '0;
      end
      WAIT_ACT: begin
        if (bus.tx_active) begin
          state_d = WAIT_DONE;
        end else begin
          timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
          if (timer_d == TMR_MAX) begin
            errTimeout_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_active) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  function automatic void doneDefault();
    done_d       = 1'b0;
    errTimeout_d = 1'b0;
  endfunction

  // State and registered outputs; reset abandons any byte in flight silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      txStart_q    <= 1'b0;
      reqReady_q   <= '0;
      txData_q     <= 8'h00;
      grantId_q    <= '0;
      lastGrant_q  <= LAST_ID;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      txStart_q    <= txStart_d;
      reqReady_q   <= reqReady_d;
      txData_q     <= txData_d;
      grantId_q    <= grantId_d;
      lastGrant_q  <= lastGrant_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  assign bus.tx_start    = txStart_q;
  assign bus.req_ready   = reqReady_q;
  assign bus.tx_data     = txData_q;
  assign bus.grant_id    = grantId_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = errTimeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with four requesters and a 16-cycle
// start timeout. Inputs change and outputs are sampled 1 time unit after
// each rising edge; expected values are worked out by hand per scenario.
module tb_uart_tx_arbiter;

  logic clk;
  logic rst;

  logic        en;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic        txActive;

  int checkCount;
  int failCount;
  int overlapCount;

  uart_tx_arbiter_if #(.NUM_REQ(4)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ  (4),
    .START_TO (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count any cycle where completion and timeout pulse together
  always @(negedge clk) begin
    if (!rst && bus.done && bus.err_timeout) overlapCount++;
  end

  // Hard stop in case some scenario stalls beyond its own bounds
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Push the bench's input variables onto the interface
  task automatic applyStimulus();
    bus.en        = en;
    bus.req_valid = reqValid;
    bus.req_data  = reqData;
    bus.tx_active = txActive;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive current inputs, then advance to just after the next rising edge
  task automatic stepCycle();
    applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges with all inputs quiet and grants enabled
  task automatic resetDut();
    en       = 1'b1;
    reqValid = 4'b0000;
    reqData  = 32'h0;
    txActive = 1'b0;
    rst      = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    applyStimulus();
  endtask

  // Expect a grant one edge later, then run the UART through a busy period
  task automatic serveByte(input int id, input logic [7:0] data, input int activeCycles);
    int n;
    n = 0;
    while (!bus.tx_start && n < 6) begin
      stepCycle();
      n++;
    end
    checkOutput($sformatf("start%0d", id), 32'(bus.tx_start), 1);
    checkOutput($sformatf("latency%0d", id), 32'(n), 1);
    checkOutput($sformatf("grantId%0d", id), 32'(bus.grant_id), 32'(id));
    checkOutput($sformatf("txData%0d", id), 32'(bus.tx_data), 32'(data));
    checkOutput($sformatf("reqReady%0d", id), 32'(bus.req_ready), 32'(1 << id));
    reqValid[id[1:0]] = 1'b0;
    stepCycle();
    checkOutput($sformatf("startPulse%0d", id), 32'(bus.tx_start), 0);
    txActive = 1'b1;
    repeat (activeCycles) stepCycle();
    checkOutput($sformatf("noEarlyDone%0d", id), 32'(bus.done), 0);
    checkOutput($sformatf("busyMid%0d", id), 32'(bus.busy), 1);
    txActive = 1'b0;
    stepCycle();
    checkOutput($sformatf("done%0d", id), 32'(bus.done), 1);
    checkOutput($sformatf("idleAfter%0d", id), 32'(bus.busy), 0);
  endtask

  // Scenario sequence
  initial begin
    int k;
    int startSeen;
    int errSeen;
    int doneSeen;
    checkCount   = 0;
    failCount    = 0;
    overlapCount = 0;

    // Reset values
    resetDut();
    rst = 1'b1;
    #1;
    checkOutput("rstTxStart", 32'(bus.tx_start), 0);
    checkOutput("rstReqReady", 32'(bus.req_ready), 0);
    checkOutput("rstBusy", 32'(bus.busy), 0);
    checkOutput("rstDone", 32'(bus.done), 0);
    checkOutput("rstErr", 32'(bus.err_timeout), 0);
    checkOutput("rstTxData", 32'(bus.tx_data), 0);
    checkOutput("rstGrantId", 32'(bus.grant_id), 0);
    rst = 1'b0;
    stepCycle();

    // Single requester, 10-cycle UART busy period
    $display("[TB] single requester");
    reqValid = 4'b0001;
    reqData  = 32'h0000_00A5;
    serveByte(0, 8'hA5, 10);
    stepCycle();
    checkOutput("donePulseOnce", 32'(bus.done), 0);

    // Fairness across four held requests, requester 0 re-asserted after its turn
    $display("[TB] fairness");
    resetDut();
    reqValid = 4'b1111;
    reqData  = 32'h1312_1110;
    serveByte(0, 8'h10, 3);
    reqValid[0]  = 1'b1;
    reqData[7:0] = 8'h20;
    serveByte(1, 8'h11, 3);
    serveByte(2, 8'h12, 3);
    serveByte(3, 8'h13, 3);
    serveByte(0, 8'h20, 3);

    // Start timeout: UART never goes active
    $display("[TB] timeout");
    resetDut();
    reqValid = 4'b0001;
    reqData  = 32'h0000_0055;
    stepCycle();
    checkOutput("toStart", 32'(bus.tx_start), 1);
    reqValid = 4'b0000;
    k = 0;
    doneSeen = 0;
    while (!bus.err_timeout && k < 30) begin
      stepCycle();
      k++;
      if (bus.done) doneSeen++;
    end
    checkOutput("toCycle", 32'(k), 17);
    checkOutput("toNoDone", 32'(doneSeen), 0);
    checkOutput("toIdle", 32'(bus.busy), 0);
    reqValid = 4'b0011;
    reqData  = 32'h0000_6655;
    stepCycle();
    checkOutput("toErrOnce", 32'(bus.err_timeout), 0);
    checkOutput("toNextStart", 32'(bus.tx_start), 1);
    checkOutput("toNextGrant", 32'(bus.grant_id), 1);

    // Reset while waiting for the UART to finish, requester 2 owning
    $display("[TB] reset mid-transfer");
    resetDut();
    reqValid = 4'b0100;
    reqData  = 32'h0077_0000;
    stepCycle();
    checkOutput("mrGrant", 32'(bus.grant_id), 2);
    reqValid = 4'b0000;
    stepCycle();
    txActive = 1'b1;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("mrBusyBefore", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("mrTxData", 32'(bus.tx_data), 0);
    checkOutput("mrGrantId", 32'(bus.grant_id), 0);
    checkOutput("mrBusy", 32'(bus.busy), 0);
    checkOutput("mrReady", 32'(bus.req_ready), 0);
    stepCycle();
    rst      = 1'b0;
    txActive = 1'b0;
    stepCycle();
    checkOutput("mrNoDone", 32'(bus.done), 0);
    checkOutput("mrNoErr", 32'(bus.err_timeout), 0);
    reqValid = 4'b1010;
    reqData  = 32'hBB00_AA00;
    stepCycle();
    checkOutput("mrRestartStart", 32'(bus.tx_start), 1);
    checkOutput("mrRestartGrant", 32'(bus.grant_id), 1);
    checkOutput("mrRestartData", 32'(bus.tx_data), 32'hAA);

    // Grant enable gating
    $display("[TB] enable gating");
    resetDut();
    en       = 1'b0;
    reqValid = 4'b1000;
    reqData  = 32'h3C00_0000;
    startSeen = 0;
    repeat (20) begin
      stepCycle();
      if (bus.tx_start) startSeen++;
    end
    checkOutput("gateNoStart", 32'(startSeen), 0);
    en = 1'b1;
    stepCycle();
    checkOutput("gateStart", 32'(bus.tx_start), 1);
    checkOutput("gateGrant", 32'(bus.grant_id), 3);
    checkOutput("gateData", 32'(bus.tx_data), 32'h3C);
    reqValid = 4'b0000;
    stepCycle();
    txActive = 1'b1;
    en       = 1'b0;
    repeat (4) stepCycle();
    txActive = 1'b0;
    stepCycle();
    checkOutput("gateDone", 32'(bus.done), 1);
    en = 1'b1;

    // UART already busy while idle blocks grants without an error
    $display("[TB] busy line");
    resetDut();
    txActive = 1'b1;
    reqValid = 4'b0001;
    reqData  = 32'h0000_005A;
    startSeen = 0;
    errSeen   = 0;
    repeat (5) begin
      stepCycle();
      if (bus.tx_start) startSeen++;
      if (bus.err_timeout) errSeen++;
    end
    checkOutput("blNoStart", 32'(startSeen), 0);
    checkOutput("blNoErr", 32'(errSeen), 0);
    txActive = 1'b0;
    stepCycle();
    checkOutput("blStart", 32'(bus.tx_start), 1);
    checkOutput("blGrant", 32'(bus.grant_id), 0);
    checkOutput("blData", 32'(bus.tx_data), 32'h5A);

    checkOutput("doneErrOverlap", 32'(overlapCount), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL take parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 SHALL take parameter START_TO, default 16: cycles allowed after tx_start for tx_active to rise.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: grant enable.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester byte pending.
REQ-007 SHALL have port req_data, input, NUM_REQ*8 bits: byte i in bits [8i+7:8i].
REQ-008 SHALL have port req_ready, output, NUM_REQ bits: one-hot accept pulse.
REQ-009 SHALL have port tx_start, output, 1 bit: one-cycle start pulse to the UART TX.
REQ-010 SHALL have port tx_data, output, 8 bits: byte to transmit.
REQ-011 SHALL have port tx_active, input, 1 bit: UART TX busy.
REQ-012 SHALL have port grant_id, output, clog2(NUM_REQ) bits: current or last owner.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a byte finishes.
REQ-015 SHALL have port err_timeout, output, 1 bit: one-cycle pulse when tx_active fails to rise.

Function
REQ-016 SHALL implement FSM states IDLE, START, WAIT_ACT, WAIT_DONE; all outputs registered.
REQ-017 In IDLE, SHALL grant when en=1, tx_active=0 and any req_valid=1 are sampled at an edge: winner chosen round-robin, req_data of the winner captured into tx_data, state -> START.
REQ-018 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward with wrap-around; last_grant SHALL update on every grant.
REQ-019 In START (exactly one cycle), tx_start=1 and req_ready[grant_id]=1; all other req_ready bits SHALL be 0; next state is WAIT_ACT, timer cleared.
REQ-020 Latency: valid sampled at edge N -> tx_start and req_ready visible in cycle N+1.
REQ-021 Requesters SHALL hold req_valid and req_data stable until req_ready; the arbiter SHALL ignore req_valid outside IDLE.
REQ-022 tx_data and grant_id SHALL stay stable from START until the next grant.
REQ-023 WAIT_ACT: tx_active=1 sampled -> WAIT_DONE; else timer increments; timer reaching START_TO with tx_active still 0 -> err_timeout=1 and IDLE in the next cycle, i.e. cycle T+START_TO+1, where T is the tx_start cycle.
REQ-024 Timer SHALL be clog2(START_TO+1) bits wide and SHALL saturate rather than wrap.
REQ-025 WAIT_DONE: tx_active=0 sampled at edge D -> done=1 and state IDLE in cycle D+1; a new grant can be sampled at the edge ending D+1.
REQ-026 en=0 SHALL block only new grants; an in-flight byte SHALL complete normally.
REQ-027 tx_active=1 while in IDLE SHALL block grants; no error is flagged.
REQ-028 done and err_timeout SHALL never assert in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE; tx_start, req_ready, busy, done, err_timeout = 0; tx_data=0x00; grant_id=0; timer=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-030 Reset mid-transfer SHALL abandon the byte without a done or err_timeout pulse; arbitration restarts from requester 0.

Verification
REQ-031 Single requester: req 0 data 0xA5 -> tx_start and req_ready=0001 in the next cycle, tx_data=0xA5, grant_id=0; tx_active high 10 cycles then low -> done one cycle later, busy=0.
REQ-032 Fairness: all four valid, data 0x10..0x13, held until accepted -> grant order 0,1,2,3; a re-asserted req 0 is granted fifth.
REQ-033 Timeout: tx_active held 0 after tx_start at cycle T -> err_timeout at T+17, back in IDLE, next grant goes to requester 1.
REQ-034 Reset mid-WAIT_DONE with req 2 owning -> all outputs at reset values, no done; reqs 1 and 3 valid after reset -> 1 granted first.
REQ-035 Gating: en=0 with req 3 valid -> no tx_start for 20 cycles; en=1 -> tx_start in the next cycle; en dropped mid-byte -> byte completes with done.
REQ-036 Busy line: tx_active=1 in IDLE with req 0 valid -> no grant until tx_active=0, then tx_start in the next cycle.
